// File: rtl/image_loader.sv
// Frame loader: accepts a raster stream of pixels through a small FIFO and
// writes them into an image SRAM, one write per cycle, then pulses load_done.
module image_loader #(
    parameter int X_MAX       = 200,
    parameter int Y_MAX       = 200,
    parameter int PIXEL_DEPTH = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     new_trans,
    input  logic [$clog2(X_MAX)-1:0] max_x,
    input  logic [$clog2(Y_MAX)-1:0] max_y,
    input  logic                     in_valid,
    input  logic [PIXEL_DEPTH-1:0]   in_data,
    output logic                     in_ready,
    output logic [$clog2(X_MAX):0]   x_addr_img,
    output logic [$clog2(Y_MAX):0]   y_addr_img,
    output logic                     wen_img,
    output logic [PIXEL_DEPTH-1:0]   wdat_img,
    output logic                     busy,
    output logic                     load_done
);

    localparam int XW = $clog2(X_MAX);
    localparam int YW = $clog2(Y_MAX);
    localparam int CW = XW + YW + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        FLAG
    } state_t;

    state_t state;
    state_t state_next;

    logic [XW-1:0]          max_x_r;
    logic [YW-1:0]          max_y_r;
    logic [XW-1:0]          pos_x;
    logic [YW-1:0]          pos_y;
    logic [CW-1:0]          acc_cnt;
    logic [CW-1:0]          frame_size;
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic [AW:0]            fifo_cnt;
    logic [PIXEL_DEPTH-1:0] mem [FIFO_DEPTH];
    logic [PIXEL_DEPTH-1:0] head;
    logic [PIXEL_DEPTH-1:0] last_dat;
    logic [XW:0]            last_x;
    logic [YW:0]            last_y;

    logic start;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic last_pos;

    always_comb begin
        start      = (state == IDLE) && new_trans;
        frame_size = (CW'(max_x_r) + CW'(1)) * (CW'(max_y_r) + CW'(1));
        fifo_cnt   = wr_ptr - rd_ptr;
        fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
        fifo_empty = (wr_ptr == rd_ptr);
        head       = mem[rd_ptr[AW-1:0]];
        last_pos   = (pos_x == max_x_r) && (pos_y == max_y_r);

        // Ready is derived only from registered state, never from in_valid.
        in_ready   = (state == LOADING) && !fifo_full && (acc_cnt < frame_size);
        push       = in_valid && in_ready;
        wen_img    = (state == LOADING) && !fifo_empty;
        busy       = (state == LOADING);
        load_done  = (state == FLAG);

        // Outside a write cycle the SRAM bus holds the last written beat.
        x_addr_img = wen_img ? {1'b0, pos_x} : last_x;
        y_addr_img = wen_img ? {1'b0, pos_y} : last_y;
        wdat_img   = wen_img ? head : last_dat;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (new_trans) state_next = LOADING;
            LOADING: if (wen_img && last_pos) state_next = FLAG;
            FLAG:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            max_x_r  <= '0;
            max_y_r  <= '0;
            pos_x    <= '0;
            pos_y    <= '0;
            acc_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            last_dat <= '0;
            last_x   <= '0;
            last_y   <= '0;
        end else if (start) begin
            max_x_r <= max_x;
            max_y_r <= max_y;
            pos_x   <= '0;
            pos_y   <= '0;
            acc_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + (AW+1)'(1);
                acc_cnt <= acc_cnt + CW'(1);
            end
            if (wen_img) begin
                rd_ptr   <= rd_ptr + (AW+1)'(1);
                last_dat <= head;
                last_x   <= {1'b0, pos_x};
                last_y   <= {1'b0, pos_y};
                if (pos_x == max_x_r) begin
                    pos_x <= '0;
                    pos_y <= pos_y + YW'(1);
                end else begin
                    pos_x <= pos_x + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: per-cycle vector table for whole frames,
// plus hand-written reset and mid-frame reset sequences.
module tb_image_loader;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       new_trans = 1'b0;
    logic [7:0] max_x = '0;
    logic [7:0] max_y = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic [8:0] x_addr_img;
    logic [8:0] y_addr_img;
    logic       wen_img;
    logic [7:0] wdat_img;
    logic       busy;
    logic       load_done;

    int n_cmp = 0;
    int n_bad = 0;

    image_loader #(
        .X_MAX(200),
        .Y_MAX(200),
        .PIXEL_DEPTH(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .new_trans(new_trans),
        .max_x(max_x),
        .max_y(max_y),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .x_addr_img(x_addr_img),
        .y_addr_img(y_addr_img),
        .wen_img(wen_img),
        .wdat_img(wdat_img),
        .busy(busy),
        .load_done(load_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic nt;
        int   mx;
        int   my;
        logic iv;
        int   d;
        logic e_rdy;
        logic e_wen;
        int   e_x;
        int   e_y;
        int   e_dat;
        logic e_busy;
        logic e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic nt, input int mx, input int my, input logic iv, input int d,
                       input logic rdy, input logic wen, input int x, input int y, input int dat,
                       input logic bsy, input logic done);
        vec_t v;
        v.nt = nt; v.mx = mx; v.my = my; v.iv = iv; v.d = d;
        v.e_rdy = rdy; v.e_wen = wen; v.e_x = x; v.e_y = y; v.e_dat = dat;
        v.e_busy = bsy; v.e_done = done;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic wen, input int x,
                           input int y, input int dat, input logic bsy, input logic done);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, ".wen_img"}, 32'(wen_img), 32'(wen));
        chk({tag, ".x_addr"}, 32'(x_addr_img), x);
        chk({tag, ".y_addr"}, 32'(y_addr_img), y);
        chk({tag, ".wdat"}, 32'(wdat_img), dat);
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
        chk({tag, ".load_done"}, 32'(load_done), 32'(done));
    endtask

    task automatic drive(input logic nt, input int mx, input int my, input logic iv, input int d);
        new_trans = nt;
        max_x     = 8'(mx);
        max_y     = 8'(my);
        in_valid  = iv;
        in_data   = 8'(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int j;
        // 4x3 stream, valid held for 20 cycles, new_trans in LOADING and FLAG, junk max inputs.
        add(1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 20; c++) begin
            logic wen;
            int x, y, dat;
            wen = (c >= 2) && (c <= 13);
            j = c - 2;
            if (wen) begin x = j % 4; y = j / 4; dat = j; end
            else if (c < 2) begin x = 0; y = 0; dat = 0; end
            else begin x = 3; y = 2; dat = 11; end
            add((c == 5) || (c == 14), 1, 1, 1, c - 1, c <= 12, wen, x, y, dat, c <= 13, c == 14);
        end
        // 1-pixel frame.
        add(1, 0, 0, 0, 0,    0, 0, 3, 2, 11,   0, 0);
        add(0, 3, 2, 1, 'hA5, 1, 0, 3, 2, 11,   1, 0);
        add(0, 3, 2, 1, 'h11, 0, 1, 0, 0, 'hA5, 1, 0);
        add(0, 3, 2, 1, 'h22, 0, 0, 0, 0, 'hA5, 0, 1);
        add(0, 3, 2, 1, 'h33, 0, 0, 0, 0, 'hA5, 0, 0);
        // Gappy 4x3 source: valid on odd cycles, data 100..111.
        add(1, 3, 2, 0, 0, 0, 0, 0, 0, 'hA5, 0, 0);
        for (int c = 1; c <= 26; c++) begin
            logic iv, wen;
            int x, y, dat;
            iv  = ((c % 2 == 1) && (c <= 23)) || (c == 25);
            wen = (c % 2 == 0) && (c >= 2) && (c <= 24);
            if (wen) j = (c - 2) / 2;
            else j = (c - 3) / 2;
            if (c == 1) begin x = 0; y = 0; dat = 'hA5; end
            else begin x = j % 4; y = j / 4; dat = 100 + j; end
            add(0, 3, 2, iv, 100 + (c - 1) / 2, c <= 23, wen, x, y, dat, c <= 24, c == 25);
        end

        // Outputs while reset is held.
        #2;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3 n_rst = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1 drive(vecs[i].nt, vecs[i].mx, vecs[i].my, vecs[i].iv, vecs[i].d);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_wen, vecs[i].e_x,
                    vecs[i].e_y, vecs[i].e_dat, vecs[i].e_busy, vecs[i].e_done);
        end

        // Mid-frame reset: 5 writes of a 4x3 frame, then asynchronous reset.
        @(posedge clk);
        #1 drive(1, 3, 2, 0, 0);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1 drive(0, 3, 2, 1, c - 1);
        end
        @(negedge clk);
        chk_all("pre_rst", 1, 1, 0, 1, 4, 1, 0);
        @(posedge clk);
        #1 drive(0, 3, 2, 1, 6);
        #1 n_rst = 1'b0;
        #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3 n_rst = 1'b1;
        @(posedge clk);
        #1 drive(0, 3, 2, 1, 7);
        @(negedge clk);
        chk_all("post_rst_idle", 0, 0, 0, 0, 0, 0, 0);

        // Restart with a 2x1 frame: must write from (0,0) again.
        @(posedge clk);
        #1 drive(1, 1, 0, 0, 0);
        @(posedge clk);
        #1 drive(0, 1, 0, 1, 50);
        @(negedge clk);
        chk_all("restart_acc0", 1, 0, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1 drive(0, 1, 0, 1, 51);
        @(negedge clk);
        chk_all("restart_wr0", 1, 1, 0, 0, 50, 1, 0);
        @(posedge clk);
        #1 drive(0, 1, 0, 0, 0);
        @(negedge clk);
        chk_all("restart_wr1", 0, 1, 1, 0, 51, 1, 0);
        @(negedge clk);
        chk_all("restart_done", 0, 0, 1, 0, 51, 0, 1);
        @(negedge clk);
        chk_all("restart_idle", 0, 0, 1, 0, 51, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
